// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART frame scheduler: FSM encoding, frame format
// and the per-index frame byte selection.
package uart_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN    = 3;
    localparam int         IDX_W        = 2;

    // Frame layout: SYNC, payload, then SYNC ^ payload as the checksum.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [7:0]       sync,
                                              input logic [7:0]       pay);
        logic [7:0] b;
        case (idx)
            2'd0:    b = sync;
            2'd1:    b = pay;
            default: b = sync ^ pay;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin winner select: a lone request wins outright, and with
// both requesting the one that was not served last wins.
module uart_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    assign valid = |req;

    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Frame scheduler in front of the UART transmitter: arbitrates two requesters
// and sends SYNC, payload, checksum for the winner, then acknowledges it.
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter logic [7:0] SYNC      = SYNC_DEFAULT,
    parameter int         FRAME_LEN = uart_ctrl_pkg::FRAME_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [7:0] payload0,
    input  logic [7:0] payload1,
    output logic [1:0] ack,
    output logic       busy,
    output logic       tx_start,
    output logic [7:0] tx_din,
    input  logic       tx_done_tick
);

    // Handshakes: req[n] is a level held with payloadN until ack[n] pulses for
    // one cycle. Toward the transmitter, tx_start pulses once per byte with
    // tx_din valid, and tx_din holds until tx_done_tick arrives in WAIT;
    // tx_done_tick in any other state is ignored.

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             sel;
    logic             last;
    logic [7:0]       pay_q;
    logic [7:0]       din_q;
    logic             arb_valid;
    logic             arb_winner;

    uart_rr_arb2 u_arb (
        .req    (req),
        .last   (last),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    assign idx_next = idx + 1'b1;

    // tx_din is loaded on entry to SEND so it is already valid with tx_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            sel   <= 1'b0;
            last  <= 1'b1;
            pay_q <= 8'h00;
            din_q <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        sel   <= arb_winner;
                        pay_q <= arb_winner ? payload1 : payload0;
                        idx   <= '0;
                        din_q <= SYNC;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: state <= ST_WAIT;
                ST_WAIT: begin
                    if (tx_done_tick) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx_next;
                            din_q <= frame_byte(idx_next, SYNC, pay_q);
                            state <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    last  <= sel;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign tx_start = (state == ST_SEND);
    assign tx_din   = din_q;
    assign ack      = (state == ST_DONE) ? (sel ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised scoreboard bench for uart_tx_sched with a behavioural transmitter
// and a frame-level reference model of arbitration and frame contents.
module tb_uart_tx_sched;

    localparam logic [7:0] SYNC_B = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [7:0] payload0;
    logic [7:0] payload1;
    logic [1:0] ack;
    logic       busy;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       tx_done_tick;
    logic       done_model;
    logic       done_stray;

    assign tx_done_tick = done_model | done_stray;

    uart_tx_sched dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .payload0     (payload0),
        .payload1     (payload1),
        .ack          (ack),
        .busy         (busy),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    // exp_q entry: {b2b_gap_check, first_byte_of_frame, byte}
    logic [9:0] exp_q[$];
    logic [1:0] exp_ack_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       model_last;
    bit         long_done = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    task automatic model_frame(input int r, input logic [7:0] p, input bit b2b);
        exp_q.push_back({b2b, 1'b1, SYNC_B});
        exp_q.push_back({2'b00, p});
        exp_q.push_back({2'b00, SYNC_B ^ p});
        exp_ack_q.push_back(r == 1 ? 2'b10 : 2'b01);
        model_last = (r == 1);
    endtask

    task automatic model_request(input logic [1:0] mask, input logic [7:0] p0,
                                 input logic [7:0] p1);
        int f;
        if (mask == 2'b11) begin
            f = model_last ? 0 : 1;
            model_frame(f, f == 1 ? p1 : p0, 1'b0);
            model_frame(1 - f, f == 1 ? p0 : p1, 1'b1);
        end else if (mask[0]) begin
            model_frame(0, p0, 1'b0);
        end else begin
            model_frame(1, p1, 1'b0);
        end
    endtask

    // ---------------- behavioural transmitter ----------------
    int pend = 0;
    bit hold = 0;
    initial begin
        done_model = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 0;
                hold = 0;
                done_model = 1'b0;
            end else begin
                if (done_model) begin
                    if (hold) hold = 0;
                    else done_model = 1'b0;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        done_model = 1'b1;
                        hold = long_done;
                    end
                end
                if (tx_start) pend = $urandom_range(1, 5);
            end
        end
    end

    // ---------------- monitor ----------------
    int         last_done_cyc = -100;
    int         start_cyc = 0;
    bit         in_byte = 0;
    logic [7:0] held_din;
    logic [9:0] e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                in_byte = 0;
            end else begin
                if (in_byte && tx_done_tick && (cyc - 1 > start_cyc)) begin
                    last_done_cyc = cyc - 1;
                    in_byte = 0;
                end else if (in_byte && cyc > start_cyc) begin
                    check("tx_din_hold", tx_din, held_din);
                end
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        fail_evt("tx_start_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_din", tx_din, e[7:0]);
                        if (!e[8]) check("byte_gap", cyc - last_done_cyc, 1);
                        else if (e[9]) check("frame_gap", cyc - last_done_cyc, 3);
                    end
                    in_byte = 1;
                    start_cyc = cyc;
                    held_din = tx_din;
                end
                if (ack != 2'b00) begin
                    if (exp_ack_q.size() == 0) begin
                        fail_evt("ack_unexpected");
                    end else begin
                        check("ack", ack, exp_ack_q.pop_front());
                        check("ack_latency", cyc - last_done_cyc, 1);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_acks(input int r0, input int r1);
        int rem0 = r0;
        int rem1 = r1;
        int budget = 0;
        while ((rem0 + rem1) > 0 && budget < 600) begin
            @(negedge clk);
            budget++;
            if (ack[0]) begin
                rem0--;
                if (rem0 <= 0) req[0] = 1'b0;
            end
            if (ack[1]) begin
                rem1--;
                if (rem1 <= 0) req[1] = 1'b0;
            end
        end
        if ((rem0 + rem1) > 0) begin
            fail_evt("ack_timeout");
            req = 2'b00;
        end
    endtask

    task automatic serve(input logic [1:0] mask, input logic [7:0] p0, input logic [7:0] p1);
        @(negedge clk);
        payload0 = p0;
        payload1 = p1;
        model_request(mask, p0, p1);
        req = mask;
        wait_acks(int'(mask[0]), int'(mask[1]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        req = 2'b00;
        payload0 = 8'h00;
        payload1 = 8'h00;
        done_stray = 1'b0;
        model_last = 1'b1;
        #1;
        check("reset_ack", ack, 0);
        check("reset_busy", busy, 0);
        check("reset_tx_start", tx_start, 0);
        check("reset_tx_din", tx_din, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // simultaneous first requests after reset
        serve(2'b11, 8'h01, 8'h02);

        // fairness: both held for four frames
        @(negedge clk);
        payload0 = 8'h3C;
        payload1 = 8'hC3;
        model_frame(model_last ? 0 : 1, model_last ? 8'h3C : 8'hC3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            model_frame(model_last ? 0 : 1, model_last ? 8'h3C : 8'hC3, 1'b1);
        end
        req = 2'b11;
        wait_acks(2, 2);

        // single request, with latency checks
        @(negedge clk);
        payload0 = 8'h35;
        model_request(2'b01, 8'h35, 8'h00);
        req = 2'b01;
        @(posedge clk);
        #1;
        check("grant_tx_start", tx_start, 1);
        check("grant_tx_din", tx_din, SYNC_B);
        @(posedge clk);
        #1;
        check("wait_tx_start", tx_start, 0);
        check("wait_busy", busy, 1);
        // payload change after grant must not alter the frame
        @(negedge clk);
        payload0 = 8'hFF;
        wait_acks(1, 0);
        @(negedge clk);
        check("idle_busy", busy, 0);

        // stray done in IDLE
        done_stray = 1'b1;
        @(negedge clk);
        done_stray = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_tx_start", tx_start, 0);
        check("stray_ack", ack, 0);

        // stray done in SEND/DONE via stretched transmitter pulses
        long_done = 1;
        serve(2'b10, 8'h00, 8'h5E);
        serve(2'b11, 8'h80, 8'h7F);
        long_done = 0;

        // randomised rounds
        for (int i = 0; i < 30; i++) begin
            long_done = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            serve(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        end
        long_done = 0;

        // reset while waiting on byte1
        begin
            int starts = 0;
            int budget = 0;
            @(negedge clk);
            payload0 = 8'h5A;
            model_request(2'b01, 8'h5A, 8'h00);
            req = 2'b01;
            while (starts < 2 && budget < 200) begin
                @(negedge clk);
                budget++;
                if (tx_start) starts++;
            end
            if (starts < 2) fail_evt("byte1_timeout");
            @(posedge clk);
            #2;
            reset = 1'b1;
            #1;
            check("abort_tx_start", tx_start, 0);
            check("abort_busy", busy, 0);
            check("abort_ack", ack, 0);
            check("abort_tx_din", tx_din, 0);
            exp_q.delete();
            exp_ack_q.delete();
            model_last = 1'b1;
            req = 2'b10;
            payload1 = 8'hC3;
            model_request(2'b10, 8'h00, 8'hC3);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            wait_acks(0, 1);
        end

        repeat (5) @(negedge clk);
        check("exp_bytes_left", exp_q.size(), 0);
        check("exp_acks_left", exp_ack_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
